execute_mdu: RTL and testbench
==============================

// Module: execute_mdu
// PURPOSE
//  Multi-cycle multiply/divide unit with HI/LO registers, inside the Execute stage directly upstream of Memory.
//  Accepts mult/multu/div/divu/mthi/mtlo from E and exposes HI/LO to mfhi/mflo.
//  Raises busy so the hazard unit stalls any MDU instruction in D.
//  Honours the M-stage exception/interrupt request: an E-stage op issued in a req cycle never commits.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//  DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//  clk        in   1   single clock, rising edge
//  reset      in   1   asynchronous, active-low; clears all state
//  mdu_op     in   3   0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 reserved(=none)
//  start      in   1   E-stage instr valid this cycle with mdu_op
//  a          in   32  forwarded rs value
//  b          in   32  forwarded rt value
//  req        in   1   exception/interrupt taken in M this cycle (flush E)
//  busy       out  1   multi-cycle op in progress
//  stall_req  out  1   busy | (start & op in 1..4 & ~req), to hazard unit
//  hi         out  32  HI register (architectural)
//  lo         out  32  LO register (architectural)
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE, cnt=0, busy=0, hi=0, lo=0, temp regs=0.
//  Accept: start & ~req & state==IDLE. start with req==1 is ignored entirely (no HI/LO write, no busy).
//  mthi/mtlo: HI<=a / LO<=a at accepting edge; busy stays 0.
//  mult/multu/div/divu: at accepting edge latch result into th/tl, cnt<=N-1, state<=RUN, busy=1 next cycle.
//   mult: {th,tl}=$signed(a)*$signed(b); multu: unsigned 64-bit product.
//   div: tl=a/b, th=a%b signed (truncate toward 0, remainder takes sign of a); divu unsigned.
//   div 0x80000000 / 0xFFFFFFFF -> tl=0x80000000, th=0.
//   b==0 for div/divu: op runs full DIV_CYCLES, HI/LO left unchanged at completion.
//  RUN: each edge cnt<=cnt-1; edge where cnt==0: HI<=th, LO<=tl, state<=IDLE, busy<=0.
//   Total busy = N cycles; HI/LO new value visible the cycle after busy falls.
//  req while RUN: op continues and commits (it is older than the faulting M instr).
//  start while RUN: illegal (hazard unit stalls); ignored, must not alter th/tl/cnt.
//  mfhi/mflo read hi/lo combinationally; stall_req prevents reads of stale values.
//  reset mid-RUN: immediately IDLE, busy=0, HI=LO=0; no late commit.
//  All arithmetic in 64-bit; no overflow exceptions from MDU.
// STRUCTURE
//  Op codes MDU_* and state encodings IDLE/RUN go in shared `include header mdu_defs.vh
//  (also used by the decoder Controller to produce mdu_op).
//  Single module, no sub-module; 2-state FSM + down-counter sized $clog2(max(MULT_CYCLES,DIV_CYCLES)).
// TESTING
//  mult a=0xFFFFFFFD b=5 start 1cyc -> busy 5 cycles; then hi=0xFFFFFFFF lo=0xFFFFFFF1.
//  divu a=7 b=2 -> busy 10 cycles; hi=1 lo=3; div a=-7 b=2 -> hi=0xFFFFFFFF lo=0xFFFFFFFD.
//  div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0; div b=0 with hi=0x11,lo=0x22 -> unchanged after 10 cyc.
//  start mult with req=1 -> busy stays 0, hi/lo unchanged; mthi a=0xABCD with req=1 -> hi unchanged.
//  mult started, req pulse at cycle 2, second start at cycle 3 -> original product commits, second ignored.
//  reset low at cycle 3 of div -> busy=0 hi=lo=0 asynchronously, no write after release.

Source files
------------

// File: rtl/execute_mdu_pkg.sv
// Shared op codes, FSM encodings and the combinational multiply/divide helper for the MDU.
// The decoder can import the same mdu_op_e values when it produces mdu_op.
package execute_mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_RSVD  = 3'd7
  } mdu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        wr;   // commit HI/LO when the op completes
  } mdu_res_t;

  function automatic logic is_long_op(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_div_op(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  // All arithmetic is done on 64-bit operands so 0x80000000 / -1 cannot overflow.
  function automatic mdu_res_t mdu_calc(input mdu_op_e op, input logic [31:0] a,
                                        input logic [31:0] b);
    mdu_res_t           res;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic        [63:0] ua;
    logic        [63:0] ub;
    logic        [63:0] prod;
    logic        [63:0] quo;
    logic        [63:0] rem;
    sa   = {{32{a[31]}}, a};
    sb   = {{32{b[31]}}, b};
    ua   = {32'd0, a};
    ub   = {32'd0, b};
    prod = 64'd0;
    quo  = 64'd0;
    rem  = 64'd0;
    res  = '0;
    case (op)
      MDU_MULT: begin
        prod   = sa * sb;
        res.hi = prod[63:32];
        res.lo = prod[31:0];
        res.wr = 1'b1;
      end
      MDU_MULTU: begin
        prod   = ua * ub;
        res.hi = prod[63:32];
        res.lo = prod[31:0];
        res.wr = 1'b1;
      end
      MDU_DIV: begin
        if (b != 32'd0) begin
          quo    = sa / sb;
          rem    = sa % sb;
          res.hi = rem[31:0];
          res.lo = quo[31:0];
          res.wr = 1'b1;
        end
      end
      MDU_DIVU: begin
        if (b != 32'd0) begin
          quo    = ua / ub;
          rem    = ua % ub;
          res.hi = rem[31:0];
          res.lo = quo[31:0];
          res.wr = 1'b1;
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/execute_mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers, in the Execute stage.
// The result is computed at issue and held in th/tl until the busy window has elapsed.
module execute_mdu
  import execute_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  mdu_op,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        req,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output mdu_state_e  fsm_state
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  mdu_op_e     op;
  mdu_state_e  state;
  mdu_state_e  state_next;
  mdu_res_t    res;
  logic [CNT_W-1:0] cnt;
  logic [31:0] th;
  logic [31:0] tl;
  logic        twr;
  logic        accept;
  logic        accept_long;
  logic        commit;

  assign op  = mdu_op_e'(mdu_op);
  assign res = mdu_calc(op, a, b);

  // A start in a req cycle is flushed; a start while RUN is an illegal overlap and is dropped.
  assign accept      = start && !req && (state == IDLE);
  assign accept_long = accept && is_long_op(op);
  assign stall_req   = busy || (start && is_long_op(op) && !req);
  assign fsm_state   = state;

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (accept_long) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == '0) begin
          commit     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      th  <= '0;
      tl  <= '0;
      twr <= 1'b0;
    end else if (accept_long) begin
      cnt <= is_div_op(op) ? DIV_LOAD : MULT_LOAD;
      th  <= res.hi;
      tl  <= res.lo;
      twr <= res.wr;
    end else if ((state == RUN) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Divide-by-zero leaves twr clear, so HI/LO keep their old values at completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
      if (twr) begin
        hi <= th;
        lo <= tl;
      end
    end else if (accept) begin
      if (op == MDU_MTHI) hi <= a;
      if (op == MDU_MTLO) lo <= a;
    end
  end

endmodule

// File: tb/tb_execute_mdu.sv
// Directed-vector bench for execute_mdu: hand-computed HI/LO results and busy window lengths.
module tb_execute_mdu;
  import execute_mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic [2:0]  mdu_op;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        req;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  mdu_state_e  fsm_state;

  int checks   = 0;
  int failures = 0;

  execute_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .mdu_op    (mdu_op),
    .start     (start),
    .a         (a),
    .b         (b),
    .req       (req),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Drives one E-stage instruction for a single cycle; returns at #1 after the edge.
  task automatic issue(input mdu_op_e op, input logic [31:0] va, input logic [31:0] vb,
                       input logic rq);
    mdu_op = op;
    a      = va;
    b      = vb;
    req    = rq;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    mdu_op = MDU_NONE;
    req    = 1'b0;
  endtask

  // Counts edges until busy drops, bounded so a stuck DUT still reaches the summary.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input mdu_op_e op, input logic [31:0] va,
                        input logic [31:0] vb, input int exp_cyc,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    issue(op, va, vb, 1'b0);
    wait_idle(n);
    check({tag, "_cycles"}, 64'(n), 64'(exp_cyc));
    check({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
    check({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
  endtask

  initial begin
    int n;
    reset  = 1'b0;
    mdu_op = MDU_NONE;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    req    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    check("reset_state", {63'd0, fsm_state}, {63'd0, IDLE});
    reset = 1'b1;
    @(posedge clk);
    #1;

    // stall_req must rise combinationally in the issue cycle of a long op
    mdu_op = MDU_MULT;
    start  = 1'b1;
    #1;
    check("stall_issue", {63'd0, stall_req}, 64'd1);
    start  = 1'b0;
    #1;
    check("stall_none", {63'd0, stall_req}, 64'd0);

    run_op("mult_neg", MDU_MULT, 32'hFFFFFFFD, 32'd5, 5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("multu_max", MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001);
    run_op("divu_7_2", MDU_DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    run_op("div_m7_2", MDU_DIV, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_ovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);

    // move-to ops write at the accepting edge and never raise busy
    issue(MDU_MTHI, 32'h11, 32'h0, 1'b0);
    check("mthi_busy", {63'd0, busy}, 64'd0);
    issue(MDU_MTLO, 32'h22, 32'h0, 1'b0);
    check("mthi_hi", {32'd0, hi}, 64'h11);
    check("mtlo_lo", {32'd0, lo}, 64'h22);

    run_op("div_zero", MDU_DIV, 32'd123, 32'd0, 10, 32'h11, 32'h22);

    // flushed issues: nothing happens
    mdu_op = MDU_MULT;
    a      = 32'd9;
    b      = 32'd9;
    req    = 1'b1;
    start  = 1'b1;
    #1;
    check("req_stall", {63'd0, stall_req}, 64'd0);
    @(posedge clk);
    #1;
    start  = 1'b0;
    req    = 1'b0;
    mdu_op = MDU_NONE;
    check("req_mult_busy", {63'd0, busy}, 64'd0);
    issue(MDU_MTHI, 32'hABCD, 32'h0, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    check("req_hi", {32'd0, hi}, 64'h11);
    check("req_lo", {32'd0, lo}, 64'h22);

    // req during RUN does not cancel; overlapping start is dropped
    issue(MDU_MULT, 32'd6, 32'd7, 1'b0);
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    check("ovl_busy", {63'd0, busy}, 64'd1);
    issue(MDU_MULTU, 32'd2, 32'd3, 1'b0);
    wait_idle(n);
    check("ovl_cycles", 64'(n), 64'd3);
    check("ovl_hi", {32'd0, hi}, 64'd0);
    check("ovl_lo", {32'd0, lo}, 64'd42);
    repeat (8) @(posedge clk);
    #1;
    check("ovl_no_second", {32'd0, lo}, 64'd42);

    // asynchronous reset in the middle of a divide
    issue(MDU_MTHI, 32'h55, 32'h0, 1'b0);
    issue(MDU_DIV, 32'd100, 32'd7, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_hi", {32'd0, hi}, 64'd0);
    check("rst_mid_lo", {32'd0, lo}, 64'd0);
    #2;
    reset = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("rst_after_busy", {63'd0, busy}, 64'd0);
    check("rst_after_hi", {32'd0, hi}, 64'd0);
    check("rst_after_lo", {32'd0, lo}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
